// File: rtl/uart_msg_arbiter.sv
// Two-source UART message arbiter: buffers one pending payload per requester,
// grants round-robin, and streams each grant as a 6-byte ASCII line "Tag:HL\r\n".
module uart_msg_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_start,
    input  logic [7:0] req0_data,
    input  logic       req1_start,
    input  logic [7:0] req1_data,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    input  logic       uart_ready,
    output logic       busy,
    output logic       grant_id,
    output logic [1:0] overflow,
    output logic       dbg_state
);

    localparam logic [7:0] TAG0 = 8'h4B;
    localparam logic [7:0] TAG1 = 8'h53;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_pend_v;
    logic [7:0]  r_pend_d0;
    logic [7:0]  r_pend_d1;
    logic        r_last_grant;
    logic [2:0]  r_idx;
    logic [7:0]  r_line_d;
    logic        r_line_id;
    logic [7:0]  r_uart_data;
    logic [1:0]  r_overflow;

    logic        w_grant_en;
    logic        w_grant_id;
    logic [7:0]  w_grant_d;
    logic        w_hs;
    logic        w_line_done;
    logic        w_clr0;
    logic        w_clr1;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    function automatic logic [7:0] line_byte(input logic [2:0] idx, input logic id,
                                             input logic [7:0] d);
        logic [7:0] b;
        case (idx)
            3'd0:    b = id ? TAG1 : TAG0;
            3'd1:    b = 8'h3A;
            3'd2:    b = hex_ascii(d[7:4]);
            3'd3:    b = hex_ascii(d[3:0]);
            3'd4:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Handshake: a byte moves on every rising edge where uart_valid and uart_ready
    // are both high; uart_data is held unchanged while uart_valid is high and
    // uart_ready is low, and uart_valid never drops before the byte is taken.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_grant_id  = r_line_id;
        w_hs        = 1'b0;
        w_line_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pend_v) begin
                    w_grant_en  = 1'b1;
                    w_grant_id  = (&r_pend_v) ? ~r_last_grant : r_pend_v[1];
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (uart_ready) begin
                    w_hs = 1'b1;
                    if (r_idx == 3'd5) begin
                        w_line_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_grant_d = w_grant_id ? r_pend_d1 : r_pend_d0;
    assign w_clr0    = w_grant_en && !w_grant_id;
    assign w_clr1    = w_grant_en && w_grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pend_v     <= 2'b00;
            r_pend_d0    <= 8'h00;
            r_pend_d1    <= 8'h00;
            r_last_grant <= 1'b1;
            r_idx        <= 3'd0;
            r_line_d     <= 8'h00;
            r_line_id    <= 1'b0;
            r_uart_data  <= 8'h00;
            r_overflow   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_en) begin
                r_line_d     <= w_grant_d;
                r_line_id    <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_idx        <= 3'd0;
                r_uart_data  <= line_byte(3'd0, w_grant_id, w_grant_d);
            end else if (w_hs && !w_line_done) begin
                r_idx       <= r_idx + 3'd1;
                r_uart_data <= line_byte(r_idx + 3'd1, r_line_id, r_line_d);
            end
            // A new start beats a same-edge grant clear, and only counts as an
            // overflow when the old payload was not just taken by that grant.
            if (req0_start) begin
                r_pend_v[0] <= 1'b1;
                r_pend_d0   <= req0_data;
                if (r_pend_v[0] && !w_clr0) r_overflow[0] <= 1'b1;
            end else if (w_clr0) begin
                r_pend_v[0] <= 1'b0;
            end
            if (req1_start) begin
                r_pend_v[1] <= 1'b1;
                r_pend_d1   <= req1_data;
                if (r_pend_v[1] && !w_clr1) r_overflow[1] <= 1'b1;
            end else if (w_clr1) begin
                r_pend_v[1] <= 1'b0;
            end
        end
    end

    assign uart_data  = r_uart_data;
    assign uart_valid = (r_state == S_SEND);
    assign busy       = (r_state == S_SEND);
    assign grant_id   = r_line_id;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter: expected line bytes are queued when a
// request is posted and compared as each byte leaves the UART handshake.
module tb_uart_msg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_start;
    logic [7:0] req0_data;
    logic       req1_start;
    logic [7:0] req1_data;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;
    logic       busy;
    logic       grant_id;
    logic [1:0] overflow;
    logic       dbg_state;

    int         n_assert = 0;
    int         n_fail = 0;
    int         hs_count = 0;
    int         cyc_n = 0;
    int         last_tag_cyc = 0;
    int         tag_period = 0;
    int         base;
    logic [7:0] exp_q[$];
    logic       held_valid = 1'b0;
    logic [7:0] held_data = 8'h00;

    uart_msg_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_start (req0_start),
        .req0_data  (req0_data),
        .req1_start (req1_start),
        .req1_data  (req1_data),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .uart_ready (uart_ready),
        .busy       (busy),
        .grant_id   (grant_id),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v <= 4'd9) return 8'h30 + 8'(v);
        return 8'h41 + 8'(v) - 8'd10;
    endfunction

    task automatic push_line(input logic id, input logic [7:0] d);
        exp_q.push_back(id ? 8'h53 : 8'h4B);
        exp_q.push_back(8'h3A);
        exp_q.push_back(hex_char(d[7:4]));
        exp_q.push_back(hex_char(d[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // One clock: monitor at the falling edge, then return just after the rising edge.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        if (uart_valid === 1'b1) begin
            if (held_valid) check("stall_stable", uart_data, held_data);
            held_valid = !uart_ready;
            held_data  = uart_data;
        end else begin
            held_valid = 1'b0;
        end
        if (uart_valid === 1'b1 && uart_ready && !rst) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_byte: observed %02h expected no byte", uart_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("line_byte", uart_data, e);
                if (e == 8'h4B || e == 8'h53) begin
                    tag_period   = cyc_n - last_tag_cyc;
                    last_tag_cyc = cyc_n;
                end
            end
            hs_count++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drain(input bit rnd);
        for (int k = 0; k < 400 && (exp_q.size() != 0 || busy); k++) begin
            if (rnd) uart_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        uart_ready = 1'b1;
        n_assert++;
        assert (exp_q.size() == 0 && !busy) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d bytes left busy=%0b expected 0 left busy=0",
                   exp_q.size(), busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req0_start = 1'b0;
        req0_data  = 8'h00;
        req1_start = 1'b0;
        req1_data  = 8'h00;
        uart_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset values
        check("rst_valid", {7'd0, uart_valid}, 8'h00);
        check("rst_data", uart_data, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_grant", {7'd0, grant_id}, 8'h00);
        check("rst_overflow", {6'd0, overflow}, 8'h00);

        // Single request with two-cycle latency
        req0_data = 8'h2B; req0_start = 1'b1;
        push_line(1'b0, 8'h2B);
        cyc();
        req0_start = 1'b0;
        check("lat_valid_e", {7'd0, uart_valid}, 8'h00);
        cyc();
        check("lat_valid_e1", {7'd0, uart_valid}, 8'h01);
        check("lat_busy_e1", {7'd0, busy}, 8'h01);
        check("lat_dbg_state", {7'd0, dbg_state}, 8'h01);
        check("lat_first_byte", uart_data, 8'h4B);
        drain(1'b0);
        check("single_busy_done", {7'd0, busy}, 8'h00);
        check("single_valid_done", {7'd0, uart_valid}, 8'h00);

        // Simultaneous requests from reset: requester 0 wins the first tie
        do_reset();
        req0_data = 8'h11; req1_data = 8'hF0;
        req0_start = 1'b1; req1_start = 1'b1;
        push_line(1'b0, 8'h11);
        push_line(1'b1, 8'hF0);
        cyc();
        req0_start = 1'b0; req1_start = 1'b0;
        drain(1'b0);
        check("tie_period", 8'(tag_period), 8'd7);
        check("tie_grant_hold", {7'd0, grant_id}, 8'h01);

        req0_data = 8'h11; req1_data = 8'hF0;
        req0_start = 1'b1; req1_start = 1'b1;
        push_line(1'b0, 8'h11);
        push_line(1'b1, 8'hF0);
        cyc();
        req0_start = 1'b0; req1_start = 1'b0;
        drain(1'b0);

        // After a lone requester-0 line, the next tie goes to requester 1
        req0_data = 8'h5E; req0_start = 1'b1;
        push_line(1'b0, 8'h5E);
        cyc();
        req0_start = 1'b0;
        drain(1'b0);
        req0_data = 8'h7A; req1_data = 8'h3C;
        req0_start = 1'b1; req1_start = 1'b1;
        push_line(1'b1, 8'h3C);
        push_line(1'b0, 8'h7A);
        cyc();
        req0_start = 1'b0; req1_start = 1'b0;
        drain(1'b0);
        check("rr_grant_hold", {7'd0, grant_id}, 8'h00);

        // Backpressure: long stall mid-line, then random ready
        base = hs_count;
        req1_data = 8'h9C; req1_start = 1'b1;
        push_line(1'b1, 8'h9C);
        cyc();
        req1_start = 1'b0;
        for (int k = 0; k < 20 && hs_count < base + 2; k++) cyc();
        uart_ready = 1'b0;
        repeat (10) cyc();
        check("stall_valid", {7'd0, uart_valid}, 8'h01);
        check("stall_remaining", 8'(exp_q.size()), 8'd4);
        drain(1'b1);

        // Overflow: two requester-1 starts while a line is in flight
        req0_data = 8'hAA; req0_start = 1'b1;
        push_line(1'b0, 8'hAA);
        cyc();
        req0_start = 1'b0;
        cyc();
        req1_data = 8'h01; req1_start = 1'b1;
        cyc();
        req1_data = 8'h02;
        cyc();
        req1_start = 1'b0;
        push_line(1'b1, 8'h02);
        check("ovf_set", {6'd0, overflow}, 8'h02);
        drain(1'b0);
        repeat (3) cyc();
        check("ovf_sticky", {6'd0, overflow}, 8'h02);
        do_reset();
        check("ovf_rst_clear", {6'd0, overflow}, 8'h00);

        // Set-vs-clear race: second start lands on the grant edge
        req0_data = 8'hD1; req0_start = 1'b1;
        push_line(1'b0, 8'hD1);
        cyc();
        req0_data = 8'hE2;
        push_line(1'b0, 8'hE2);
        cyc();
        req0_start = 1'b0;
        drain(1'b0);
        check("race_no_ovf", {6'd0, overflow}, 8'h00);

        // Reset mid-line with requester 1 pending
        base = hs_count;
        req0_data = 8'h33; req0_start = 1'b1;
        exp_q.push_back(8'h4B);
        exp_q.push_back(8'h3A);
        cyc();
        req0_start = 1'b0;
        req1_data = 8'h44; req1_start = 1'b1;
        cyc();
        req1_start = 1'b0;
        for (int k = 0; k < 20 && hs_count < base + 2; k++) cyc();
        check("mid_two_bytes", 8'(hs_count - base), 8'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_valid", {7'd0, uart_valid}, 8'h00);
        check("mid_rst_data", uart_data, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'h00);
        check("mid_rst_grant", {7'd0, grant_id}, 8'h00);
        check("mid_rst_overflow", {6'd0, overflow}, 8'h00);
        repeat (12) cyc();
        check("mid_quiet_valid", {7'd0, uart_valid}, 8'h00);
        check("final_queue_empty", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
